// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC-S15 run-control block: FSM states and the
// per-core reset-release helper.
package wisc_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RESET = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_FAIL  = 3'd4
    } state_e;

    // Number of release-counter cycles core <core> stays in reset.
    function automatic int rel_limit(input int rst_cycles, input int stagger, input int core);
        return rst_cycles + core * stagger;
    endfunction

endpackage

// File: rtl/wisc_stall_mon.sv
// Per-core stalled-PC detector: counts consecutive cycles with an unchanged,
// un-halted PC while enabled and flags the cycle the run reaches the limit.
module wisc_stall_mon #(
    parameter int PC_W        = 16,
    parameter int STALL_LIMIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            halt,
    input  logic [PC_W-1:0] pc,
    output logic            stalled
);

    localparam int CW = $clog2(STALL_LIMIT);

    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            same;

    always_comb begin
        same      = en && !halt && (pc == last_pc_q);
        last_pc_d = pc;
        cnt_d     = same ? cnt_q + 1'b1 : '0;
        // Fires on the cycle the counter would reach STALL_LIMIT-1.
        stalled   = same && (cnt_q == CW'(STALL_LIMIT - 2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            last_pc_q <= last_pc_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/wisc_run_ctrl.sv
// Run control for WISC-S15 cores: staggered reset release, run-cycle counting,
// and run termination on all-halted, timeout or stalled PC.
module wisc_run_ctrl
    import wisc_pkg::*;
#(
    parameter int NUM_CORES   = 2,
    parameter int PC_W        = 16,
    parameter int RST_CYCLES  = 2,
    parameter int STAGGER     = 1,
    parameter int TIMEOUT     = 250,
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_CORES-1:0]      halt_in,
    input  logic [NUM_CORES*PC_W-1:0] pc_in,
    output logic [NUM_CORES-1:0]      core_rst,
    output logic                      running,
    output logic                      done,
    output logic                      timeout,
    output logic                      stall_err,
    output logic [$clog2(NUM_CORES):0] stall_core,
    output logic [NUM_CORES-1:0]      halted_mask,
    output logic [CNT_W-1:0]          cycle_count
);

    localparam int REL_MAX = rel_limit(RST_CYCLES, STAGGER, NUM_CORES - 1);
    localparam int REL_W   = $clog2(REL_MAX + 1);
    localparam int SC_W    = $clog2(NUM_CORES) + 1;

    // state   | meaning
    // IDLE    | after rst, cores held in reset, waiting for start
    // RESET   | release counter running, cores released one by one
    // RUN     | cores executing, cycle/halt/stall monitoring active
    // DONE    | all cores halted, cores frozen in reset
    // FAIL    | timeout or stall, cores frozen in reset
    state_e               state_q, state_d;
    logic [REL_W-1:0]     rel_cnt_q, rel_cnt_d, rel_next;
    logic [NUM_CORES-1:0] core_rst_q, core_rst_d;
    logic [NUM_CORES-1:0] halted_mask_q, halted_mask_d;
    logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
    logic                 done_q, done_d, timeout_q, timeout_d, stall_err_q, stall_err_d;
    logic [SC_W-1:0]      stall_core_q, stall_core_d, stall_idx;
    logic [NUM_CORES-1:0] stalled;
    logic                 run_en, all_halted;

    assign run_en = (state_q == S_RUN);

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_mon
        wisc_stall_mon #(
            .PC_W        (PC_W),
            .STALL_LIMIT (STALL_LIMIT)
        ) u_mon (
            .clk     (clk),
            .rst     (rst),
            .en      (run_en),
            .halt    (halt_in[g]),
            .pc      (pc_in[g*PC_W +: PC_W]),
            .stalled (stalled[g])
        );
    end

    always_comb begin
        state_d       = state_q;
        rel_cnt_d     = rel_cnt_q;
        core_rst_d    = core_rst_q;
        halted_mask_d = halted_mask_q;
        cycle_count_d = cycle_count_q;
        done_d        = done_q;
        timeout_d     = timeout_q;
        stall_err_d   = stall_err_q;
        stall_core_d  = stall_core_q;
        rel_next      = rel_cnt_q + 1'b1;
        all_halted    = &(halted_mask_q | halt_in);
        stall_idx     = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (stalled[i]) stall_idx = SC_W'(i);
        end

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                core_rst_d = '1;
                if (start) begin
                    state_d       = S_RESET;
                    rel_cnt_d     = '0;
                    done_d        = 1'b0;
                    timeout_d     = 1'b0;
                    stall_err_d   = 1'b0;
                    stall_core_d  = '0;
                    halted_mask_d = '0;
                end
            end
            S_RESET: begin
                rel_cnt_d = rel_next;
                for (int i = 0; i < NUM_CORES; i++) begin
                    core_rst_d[i] = (int'(rel_next) < rel_limit(RST_CYCLES, STAGGER, i));
                end
                if (int'(rel_next) >= REL_MAX) begin
                    state_d       = S_RUN;
                    cycle_count_d = '0;
                end
            end
            S_RUN: begin
                cycle_count_d = cycle_count_q + 1'b1;
                halted_mask_d = halted_mask_q | halt_in;
                // Exit priority: all halted, then timeout, then stall.
                if (all_halted) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    core_rst_d = '1;
                end else if (cycle_count_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d    = S_FAIL;
                    timeout_d  = 1'b1;
                    core_rst_d = '1;
                end else if (|stalled) begin
                    state_d      = S_FAIL;
                    stall_err_d  = 1'b1;
                    stall_core_d = stall_idx;
                    core_rst_d   = '1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                core_rst_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rel_cnt_q     <= '0;
            core_rst_q    <= '1;
            halted_mask_q <= '0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            stall_err_q   <= 1'b0;
            stall_core_q  <= '0;
        end else begin
            state_q       <= state_d;
            rel_cnt_q     <= rel_cnt_d;
            core_rst_q    <= core_rst_d;
            halted_mask_q <= halted_mask_d;
            cycle_count_q <= cycle_count_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            stall_err_q   <= stall_err_d;
            stall_core_q  <= stall_core_d;
        end
    end

    assign core_rst    = core_rst_q;
    assign running     = run_en;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign stall_err   = stall_err_q;
    assign stall_core  = stall_core_q;
    assign halted_mask = halted_mask_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_wisc_run_ctrl.sv
// Bench for wisc_run_ctrl: per-run PC/halt tables, a run-outcome reference
// model feeding a scoreboard queue, and a negedge monitor consuming it.
module tb_wisc_run_ctrl;

    localparam int NUM_CORES   = 2;
    localparam int PC_W        = 16;
    localparam int RST_CYCLES  = 2;
    localparam int STAGGER     = 1;
    localparam int TIMEOUT     = 250;
    localparam int STALL_LIMIT = 16;
    localparam int CNT_W       = 16;
    localparam int MAXN        = TIMEOUT + 5;
    localparam int BIG         = 1000000;
    localparam int K_REL0      = 0;
    localparam int K_RUN       = 1;
    localparam int K_TERM      = 2;

    typedef struct {
        int   kind;
        int   lat;
        logic done;
        logic to;
        logic se;
        int   score;
        int   hmask;
        int   cc;
    } exp_t;

    logic                      clk;
    logic                      rst;
    logic                      start;
    logic [NUM_CORES-1:0]      halt_in;
    logic [NUM_CORES*PC_W-1:0] pc_in;
    logic [NUM_CORES-1:0]      core_rst;
    logic                      running, done, timeout, stall_err;
    logic [$clog2(NUM_CORES):0] stall_core;
    logic [NUM_CORES-1:0]      halted_mask;
    logic [CNT_W-1:0]          cycle_count;

    logic [PC_W-1:0] pc_tab   [NUM_CORES][MAXN];
    logic            halt_tab [NUM_CORES][MAXN];
    logic [PC_W-1:0] pc_pre   [NUM_CORES];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    exp_t sb[$];

    wisc_run_ctrl #(
        .NUM_CORES(NUM_CORES), .PC_W(PC_W), .RST_CYCLES(RST_CYCLES), .STAGGER(STAGGER),
        .TIMEOUT(TIMEOUT), .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .halt_in(halt_in), .pc_in(pc_in),
        .core_rst(core_rst), .running(running), .done(done), .timeout(timeout),
        .stall_err(stall_err), .stall_core(stall_core), .halted_mask(halted_mask),
        .cycle_count(cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic take(input int kind, input string nm, output exp_t e, output bit ok);
        ok = 1'b0;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: got unexpected event want no event", nm);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind) begin
                bad++;
                $display("FAIL %s: got event kind %0d want kind %0d", nm, kind, e.kind);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Monitor: consumes scoreboard entries on release, run entry and run end.
    initial begin
        logic prev_c0, prev_run, prev_term, term_now;
        exp_t e;
        bit   ok;
        prev_c0 = 1'b1;
        prev_run = 1'b0;
        prev_term = 1'b0;
        forever begin
            @(negedge clk);
            term_now = (done === 1'b1) || (timeout === 1'b1) || (stall_err === 1'b1);
            if (prev_c0 && core_rst[0] === 1'b0) begin
                take(K_REL0, "core0_release", e, ok);
                if (ok) chk("core0_release_latency", cyc - start_cyc, e.lat);
            end
            if (!prev_run && running === 1'b1) begin
                take(K_RUN, "run_entry", e, ok);
                if (ok) begin
                    chk("run_entry_latency", cyc - start_cyc, e.lat);
                    chk("run_entry_core_rst", core_rst, 0);
                end
            end
            if (!prev_term && term_now) begin
                take(K_TERM, "run_end", e, ok);
                if (ok) begin
                    chk("end_done", done, e.done);
                    chk("end_timeout", timeout, e.to);
                    chk("end_stall_err", stall_err, e.se);
                    if (e.se) chk("end_stall_core", stall_core, e.score);
                    chk("end_halted_mask", halted_mask, e.hmask);
                    chk("end_cycle_count", cycle_count, e.cc);
                    chk("end_core_rst", core_rst, {NUM_CORES{1'b1}});
                    chk("end_running", running, 0);
                end
            end
            prev_c0   = (core_rst[0] === 1'b1);
            prev_run  = (running === 1'b1);
            prev_term = term_now;
        end
    end

    // Outcome of one run from its tables: first halt per core, first cycle a
    // core has shown the same PC for STALL_LIMIT cycles, earliest ending wins.
    task automatic model(output exp_t e);
        int fh[NUM_CORES];
        int s[NUM_CORES];
        int run, h, smin, end_n;
        logic [PC_W-1:0] prev;
        h = 0;
        smin = BIG;
        for (int i = 0; i < NUM_CORES; i++) begin
            fh[i] = BIG;
            s[i] = BIG;
            run = 0;
            prev = pc_pre[i];
            for (int n = 0; n < TIMEOUT; n++) begin
                if (halt_tab[i][n] && fh[i] == BIG) fh[i] = n;
                if (pc_tab[i][n] == prev && !halt_tab[i][n]) run++;
                else run = 0;
                prev = pc_tab[i][n];
                if (run == STALL_LIMIT - 1 && s[i] == BIG) s[i] = n;
            end
            if (fh[i] > h) h = fh[i];
            if (s[i] < smin) smin = s[i];
        end
        end_n = TIMEOUT - 1;
        if (h < end_n) end_n = h;
        if (smin < end_n) end_n = smin;
        e.kind  = K_TERM;
        e.lat   = 0;
        e.cc    = end_n + 1;
        e.done  = (h == end_n);
        e.to    = !e.done && (end_n == TIMEOUT - 1);
        e.se    = !e.done && !e.to;
        e.score = 0;
        if (e.se) begin
            for (int i = NUM_CORES - 1; i >= 0; i--) if (s[i] == end_n) e.score = i;
        end
        e.hmask = 0;
        for (int i = 0; i < NUM_CORES; i++) if (fh[i] <= end_n) e.hmask = e.hmask | (1 << i);
    endtask

    task automatic fill_inc();
        for (int i = 0; i < NUM_CORES; i++) begin
            pc_pre[i] = PC_W'(16'h0100 + i * 16'h1000);
            for (int n = 0; n < MAXN; n++) begin
                pc_tab[i][n]   = PC_W'(16'h0100 + i * 16'h1000 + n + 1);
                halt_tab[i][n] = 1'b0;
            end
        end
    endtask

    task automatic fill_random();
        int cur, hold, ht;
        bit pulse;
        for (int i = 0; i < NUM_CORES; i++) begin
            cur   = int'($urandom_range(0, 65535));
            pc_pre[i] = PC_W'(cur);
            hold  = 0;
            ht    = int'($urandom_range(0, 400));
            pulse = ($urandom_range(0, 3) == 0);
            for (int n = 0; n < MAXN; n++) begin
                if (hold > 0) hold--;
                else begin
                    cur = cur + 1 + int'($urandom_range(0, 3));
                    if ($urandom_range(0, 24) == 0) hold = int'($urandom_range(4, 24));
                end
                pc_tab[i][n]   = PC_W'(cur);
                halt_tab[i][n] = pulse ? (n == ht) : (n >= ht);
            end
        end
    endtask

    task automatic drive(input int n);
        for (int i = 0; i < NUM_CORES; i++) begin
            pc_in[i*PC_W +: PC_W] = pc_tab[i][n];
            halt_in[i]            = halt_tab[i][n];
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_core_rst"}, core_rst, {NUM_CORES{1'b1}});
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_stall_err"}, stall_err, 0);
        chk({tag, "_stall_core"}, stall_core, 0);
        chk({tag, "_halted_mask"}, halted_mask, 0);
        chk({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    task automatic do_run(input int abort_at, input int start_at);
        exp_t e;
        int n, w;
        e.done = 1'b0; e.to = 1'b0; e.se = 1'b0; e.score = 0; e.hmask = 0; e.cc = 0;
        e.kind = K_REL0;
        e.lat  = RST_CYCLES + 1;
        sb.push_back(e);
        e.kind = K_RUN;
        e.lat  = RST_CYCLES + (NUM_CORES - 1) * STAGGER + 1;
        sb.push_back(e);
        if (abort_at < 0) begin
            model(e);
            sb.push_back(e);
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            pc_in[i*PC_W +: PC_W] = pc_pre[i];
        end
        halt_in   = '0;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("restart_done_clear", done, 0);
        chk("restart_timeout_clear", timeout, 0);
        chk("restart_stall_err_clear", stall_err, 0);
        chk("restart_stall_core_clear", stall_core, 0);
        chk("restart_halted_mask_clear", halted_mask, 0);
        w = 0;
        while (running !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("run_entry_seen", {31'b0, running === 1'b1}, 1);
        n = 0;
        while (running === 1'b1 && n < MAXN) begin
            if (n == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_idle_outputs("abort");
                break;
            end
            drive(n);
            start = (n == start_at);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        w = 0;
        while (sb.size() != 0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        halt_in = '0;
        pc_in   = '0;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");

        // start coinciding with rst must not launch a run
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("start_in_rst_running", running, 0);
        chk("start_in_rst_core_rst", core_rst, {NUM_CORES{1'b1}});

        // both cores halt (core 0 at 10, core 1 at 20), start mid-run ignored
        fill_inc();
        for (int n = 0; n < MAXN; n++) begin
            halt_tab[0][n] = (n >= 10);
            halt_tab[1][n] = (n >= 20);
        end
        do_run(-1, 5);

        fill_inc();
        do_run(-1, -1);

        // core 1 PC frozen from RUN cycle 5
        fill_inc();
        for (int n = 5; n < MAXN; n++) pc_tab[1][n] = 16'h0040;
        do_run(-1, -1);

        // last halt and a core-0 stall land on the same cycle
        fill_inc();
        for (int n = 0; n < MAXN; n++) begin
            pc_tab[0][n]   = PC_W'(16'h0100 + 1 + ((n < 4) ? n : 4));
            halt_tab[0][n] = (n == 3);
            halt_tab[1][n] = (n >= 19);
        end
        do_run(-1, -1);

        fill_inc();
        do_run(40, -1);

        for (int r = 0; r < 10; r++) begin
            fill_random();
            do_run(-1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
